// File: rtl/riscv_pkg.sv
// Shared RV32 control definitions: opcodes, ALU operation codes, FSM states and
// the registered control word handed from decode to the datapath.
package riscv_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [3:0] AluR      = 4'b0110;
    localparam logic [3:0] AluImm    = 4'b0010;
    localparam logic [3:0] AluLoad   = 4'b0000;
    localparam logic [3:0] AluStore  = 4'b0100;
    localparam logic [3:0] AluBranch = 4'b1100;
    localparam logic [3:0] AluLui    = 4'b0111;
    localparam logic [3:0] AluAuipc  = 4'b0011;
    localparam logic [3:0] AluJump   = 4'b1101;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic [1:0] auipc_lui;
        logic [1:0] jal_jalr;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Purely combinational opcode -> control word decode; legal_o low for any
// opcode outside the supported RV32I subset.
module opcode_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       legal_o
);

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.auipc_lui = 2'b10;
        legal_o          = 1'b1;
        case (opcode_i)
            OpR:      ctrl_o.alu_op = AluR;
            OpImm:    begin ctrl_o.alu_op = AluImm;   ctrl_o.alu_src = 1'b1; end
            OpLoad:   begin
                ctrl_o.alu_op  = AluLoad;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.is_load = 1'b1;
            end
            OpStore:  begin
                ctrl_o.alu_op   = AluStore;
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.is_store = 1'b1;
            end
            OpBranch: begin ctrl_o.alu_op = AluBranch; ctrl_o.is_branch = 1'b1; end
            OpLui:    begin
                ctrl_o.alu_op    = AluLui;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.auipc_lui = 2'b01;
            end
            OpAuipc:  begin
                ctrl_o.alu_op    = AluAuipc;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.auipc_lui = 2'b00;
            end
            OpJal:    begin ctrl_o.alu_op = AluJump; ctrl_o.jal_jalr = 2'b11; end
            OpJalr:   begin
                ctrl_o.alu_op   = AluJump;
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.jal_jalr = 2'b10;
            end
            default:  begin ctrl_o = '0; legal_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/exec/mem/wb sequencing with
// handshake timeouts, sticky trap flags and a retired-instruction counter.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [6:0]  opcode_i,
    input  logic        imem_valid_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        branch_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_o,
    output logic        reg_write_o,
    output logic [3:0]  alu_op_o,
    output logic [1:0]  auipc_lui_o,
    output logic [1:0]  jal_jalr_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [31:0] instret_o
);

    state_e      state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d, dec_ctrl;
    logic        dec_legal;
    logic        req_q, req_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d, timeout_q, timeout_d;
    logic        wait_expired;

    opcode_decode u_decode (
        .opcode_i (opcode_i),
        .ctrl_o   (dec_ctrl),
        .legal_o  (dec_legal)
    );

    assign wait_expired = (wait_q + 32'd1) >= TO_CYCLES;

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StFetch: begin
                // req_q is low only in the first cycle after reset release.
                if (req_q) begin
                    if (imem_valid_i) begin
                        state_d = StDecode;
                    end else if (wait_expired) begin
                        state_d   = StTrap;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 32'd1;
                    end
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    ctrl_d  = dec_ctrl;
                    state_d = StExec;
                end else begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                wait_d = '0;
                if (ctrl_q.is_load || ctrl_q.is_store) begin
                    state_d = StMem;
                end else if (ctrl_q.is_branch) begin
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ready_i) begin
                    wait_d  = '0;
                    state_d = ctrl_q.is_load ? StWb : StFetch;
                end else if (wait_expired) begin
                    state_d   = StTrap;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StWb: begin
                wait_d  = '0;
                state_d = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

    assign req_d = (state_d == StFetch);

    // IRWrite and the store-completion PCWrite qualify a registered state with
    // the handshake input so they land in the handshake cycle itself.
    assign imem_req_o   = req_q;
    assign ir_write_o   = req_q & imem_valid_i;
    assign pc_write_o   = (state_q == StWb)
                        | ((state_q == StMem) & ctrl_q.is_store & dmem_ready_i);
    assign branch_o     = (state_q == StExec) & ctrl_q.is_branch;
    assign reg_write_o  = (state_q == StWb);
    assign mem_read_o   = (state_q == StMem) & ctrl_q.is_load;
    assign mem_write_o  = (state_q == StMem) & ctrl_q.is_store;
    assign mem_to_reg_o = ctrl_q.is_load;
    assign alu_src_o    = ctrl_q.alu_src;
    assign alu_op_o     = ctrl_q.alu_op;
    assign auipc_lui_o  = ctrl_q.auipc_lui;
    assign jal_jalr_o   = ctrl_q.jal_jalr;
    assign state_o      = state_q;
    assign illegal_o    = illegal_q;
    assign timeout_o    = timeout_q;
    assign instret_o    = instret_q;

    assign instret_d = instret_q + {31'd0, (pc_write_o | branch_o)};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StFetch;
            ctrl_q    <= '0;
            req_q     <= 1'b0;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            req_q     <= req_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push
// per-cycle expected outputs; a monitor compares them on the falling edge.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = '0;
    logic        imem_valid = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, ir_write, pc_write, branch, mem_read, mem_write;
    logic        mem_to_reg, alu_src, reg_write, illegal, timeout;
    logic [3:0]  alu_op;
    logic [1:0]  auipc_lui, jal_jalr;
    logic [2:0]  state;
    logic [31:0] instret;

    multicycle_ctrl #(.TO_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset), .opcode_i(opcode),
        .imem_valid_i(imem_valid), .dmem_ready_i(dmem_ready),
        .imem_req_o(imem_req), .ir_write_o(ir_write), .pc_write_o(pc_write),
        .branch_o(branch), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_to_reg_o(mem_to_reg), .alu_src_o(alu_src), .reg_write_o(reg_write),
        .alu_op_o(alu_op), .auipc_lui_o(auipc_lui), .jal_jalr_o(jal_jalr),
        .state_o(state), .illegal_o(illegal), .timeout_o(timeout), .instret_o(instret)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, ST = 3'd5;
    // strobes {imem_req, ir_write, pc_write, branch, reg_write, mem_read, mem_write}
    localparam logic [6:0] K_FV = 7'b1100000, K_FW = 7'b1000000, K_WB = 7'b0010100;
    localparam logic [6:0] K_BR = 7'b0001000, K_LD = 7'b0000010, K_SDN = 7'b0010001;
    localparam logic [6:0] K_SW = 7'b0000001, K_0 = 7'b0000000;
    // control word {alu_op, alu_src, auipc_lui, jal_jalr, mem_to_reg}
    localparam logic [9:0] CW_R = 10'b0110_0_10_00_0, CW_I = 10'b0010_1_10_00_0;
    localparam logic [9:0] CW_L = 10'b0000_1_10_00_1, CW_S = 10'b0100_1_10_00_0;
    localparam logic [9:0] CW_B = 10'b1100_0_10_00_0, CW_LUI = 10'b0111_1_01_00_0;
    localparam logic [9:0] CW_AUI = 10'b0011_1_00_00_0, CW_JAL = 10'b1101_0_10_11_0;
    localparam logic [9:0] CW_JALR = 10'b1101_1_10_10_0;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [6:0]  strb;
        logic [9:0]  cw;
        logic [1:0]  flags;
        logic [31:0] instret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0, n_fail = 0;
    logic [9:0]  cw_cur = '0;
    logic [1:0]  flags_cur = '0;   // {illegal, timeout}
    logic [31:0] ir_cur = '0;

    task automatic step(input string tag, input logic rst, input logic iv, input logic dr,
                        input logic [6:0] op, input logic [2:0] st, input logic [6:0] strb);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; imem_valid = iv; dmem_ready = dr; opcode = op;
        e.tag = tag; e.st = st; e.strb = strb; e.cw = cw_cur;
        e.flags = flags_cur; e.instret = ir_cur;
        sb_q.push_back(e);
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op, input logic [9:0] cw);
        step({tag, "_fetch"}, 0, 1, 1, op, SF, K_FV);
        step({tag, "_decode"}, 0, 1, 1, op, SD, K_0);
        cw_cur = cw;
        step({tag, "_exec"}, 0, 1, 1, op, SE, K_0);
        step({tag, "_wb"}, 0, 1, 1, op, SW, K_WB);
        ir_cur++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if ({state, imem_req, ir_write, pc_write, branch, reg_write, mem_read, mem_write,
                     alu_op, alu_src, auipc_lui, jal_jalr, mem_to_reg, illegal, timeout, instret}
                    !== {e.st, e.strb, e.cw, e.flags, e.instret}) begin
                    n_fail++;
                    $display("FAIL %s: got st=%0d strb=%b cw=%b%b%b%b%b fl=%b%b instret=%0d, required st=%0d strb=%b cw=%b fl=%b instret=%0d",
                             e.tag, state,
                             {imem_req, ir_write, pc_write, branch, reg_write, mem_read, mem_write},
                             alu_op, alu_src, auipc_lui, jal_jalr, mem_to_reg, illegal, timeout,
                             instret, e.st, e.strb, e.cw, e.flags, e.instret);
                end
            end
        end
    end

    initial begin
        logic [6:0] ops [5];
        logic [9:0] cws [5];
        ops = '{7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        cws = '{CW_I, CW_LUI, CW_AUI, CW_JAL, CW_JALR};

        step("reset0", 1, 0, 0, 7'd0, SF, K_0);
        step("reset1", 1, 0, 0, 7'd0, SF, K_0);
        step("release", 0, 1, 1, 7'd0, SF, K_0);

        run_alu("add", 7'b0110011, CW_R);

        step("beq_fetch", 0, 1, 1, 7'b1100011, SF, K_FV);
        step("beq_decode", 0, 1, 1, 7'b1100011, SD, K_0);
        cw_cur = CW_B;
        step("beq_exec", 0, 1, 1, 7'b1100011, SE, K_BR);
        ir_cur++;

        step("lw_fetch", 0, 1, 0, 7'b0000011, SF, K_FV);
        step("lw_decode", 0, 1, 0, 7'b0000011, SD, K_0);
        cw_cur = CW_L;
        step("lw_exec", 0, 1, 0, 7'b0000011, SE, K_0);
        for (int i = 0; i < 3; i++) step("lw_memwait", 0, 1, 0, 7'b0000011, SM, K_LD);
        step("lw_memdone", 0, 1, 1, 7'b0000011, SM, K_LD);
        step("lw_wb", 0, 1, 1, 7'b0000011, SW, K_WB);
        ir_cur++;

        for (int i = 0; i < 5; i++) run_alu($sformatf("alu%0d", i), ops[i], cws[i]);

        step("sw_fetch", 0, 1, 1, 7'b0100011, SF, K_FV);
        step("sw_decode", 0, 1, 1, 7'b0100011, SD, K_0);
        cw_cur = CW_S;
        step("sw_exec", 0, 1, 1, 7'b0100011, SE, K_0);
        step("sw_mem", 0, 1, 1, 7'b0100011, SM, K_SDN);
        ir_cur++;

        step("sw2_fetch", 0, 1, 0, 7'b0100011, SF, K_FV);
        step("sw2_decode", 0, 1, 0, 7'b0100011, SD, K_0);
        step("sw2_exec", 0, 1, 0, 7'b0100011, SE, K_0);
        step("sw2_memwait", 0, 1, 0, 7'b0100011, SM, K_SW);
        cw_cur = '0; ir_cur = '0;
        step("sw2_async_rst", 1, 0, 0, 7'd0, SF, K_0);
        step("release2", 0, 0, 0, 7'd0, SF, K_0);

        for (int i = 0; i < 8; i++) step("imem_wait", 0, 0, 0, 7'd0, SF, K_FW);
        flags_cur = 2'b01;
        for (int i = 0; i < 3; i++) step("timeout_trap", 0, 1, 1, 7'b0110011, ST, K_0);

        flags_cur = 2'b00;
        step("reset3", 1, 0, 0, 7'd0, SF, K_0);
        step("release3", 0, 0, 0, 7'd0, SF, K_0);
        for (int i = 0; i < 7; i++) step("imem_wait7", 0, 0, 0, 7'd0, SF, K_FW);
        run_alu("add_late", 7'b0110011, CW_R);

        step("ill_fetch", 0, 1, 1, 7'd0, SF, K_FV);
        step("ill_decode", 0, 1, 1, 7'd0, SD, K_0);
        flags_cur = 2'b10;
        for (int i = 0; i < 100; i++) step("illegal_trap", 0, i[0], 1, 7'd0, ST, K_0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
